// File: rtl/bitstream_shift_engine.sv
// bitstream_shift_engine
// Serial configuration back-end. It takes 32-bit bitstream words over a
// valid/ready handshake and shifts them MSB-first into the configuration
// chain on fpga_head, generating prog_clk with a half-period of CLK_DIV clk
// cycles. It keeps a running wrapping checksum of the words it accepts.
//
// Build option: define BITSTREAM_READBACK_EN to build the fpga_tail capture
// path, the rd_data/rd_valid readback port and the WAIT_RD stall state.
// Without it, rd_data/rd_valid are tied to zero and rd_ready is ignored.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start
// S_LOAD     | word_ready high, waiting for the next bitstream word
// S_SHIFT_LO | prog_clk low, fpga_head holds the current bit
// S_SHIFT_HI | prog_clk high; its last cycle samples fpga_tail
// S_WAIT_RD  | word finished but previous readback word not yet taken
// S_DONE     | one-cycle done pulse, then back to idle

module bitstream_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] bit_length,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] checksum,
    output logic        busy,
    output logic        done,
    output logic        prog_clk,
    output logic        fpga_head,
    input  logic        fpga_tail
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_RD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Half-period timer is a down-counter reloaded with this value.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [31:0] shift_reg;
    logic [31:0] remaining;
    logic [5:0]  word_bits;
    logic        bit_end;
    logic        word_end;
    logic        rd_stall;

    // bit_end marks the clk edge that closes a SHIFT_HI phase.
    assign bit_end  = (state == S_SHIFT_HI) && (div_cnt == 8'd0);
    assign word_end = bit_end && (word_bits == 6'd1);

`ifdef BITSTREAM_READBACK_EN
    logic [31:0] capture;

    // A finished word must wait if the consumer has not taken the previous one.
    assign rd_stall = rd_valid & ~rd_ready;

    // Capture fpga_tail at the end of each high phase and publish whole words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (abort) begin
            rd_valid <= 1'b0;
        end else begin
            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;
            if (word_valid && word_ready)
                capture <= '0;
            if (bit_end) begin
                capture <= {capture[30:0], fpga_tail};
                if (word_end && !rd_stall) begin
                    rd_data  <= {capture[30:0], fpga_tail};
                    rd_valid <= 1'b1;
                end
            end
            if (state == S_WAIT_RD && rd_ready) begin
                rd_data  <= capture;
                rd_valid <= 1'b1;
            end
        end
    end
`else
    logic readback_unused;

    assign readback_unused = rd_ready ^ fpga_tail;
    assign rd_stall        = 1'b0;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

    // Sequencing FSM; every output it owns is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            shift_reg  <= '0;
            remaining  <= '0;
            word_bits  <= '0;
            checksum   <= '0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prog_clk   <= 1'b0;
            fpga_head  <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prog_clk   <= 1'b0;
            fpga_head  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        checksum <= '0;
                        if (bit_length != 32'd0) begin
                            remaining  <= bit_length;
                            word_ready <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        shift_reg  <= word_data;
                        checksum   <= checksum + word_data;
                        word_bits  <= (remaining >= 32'd32) ? 6'd32 : remaining[5:0];
                        fpga_head  <= word_data[31];
                        div_cnt    <= DIV_LAST;
                        word_ready <= 1'b0;
                        state      <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (div_cnt == 8'd0) begin
                        prog_clk <= 1'b1;
                        div_cnt  <= DIV_LAST;
                        state    <= S_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (div_cnt == 8'd0) begin
                        prog_clk  <= 1'b0;
                        shift_reg <= shift_reg << 1;
                        remaining <= remaining - 32'd1;
                        word_bits <= word_bits - 6'd1;
                        if (word_end) begin
                            if (rd_stall) begin
                                state <= S_WAIT_RD;
                            end else if (remaining == 32'd1) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                word_ready <= 1'b1;
                                state      <= S_LOAD;
                            end
                        end else begin
                            fpga_head <= shift_reg[30];
                            div_cnt   <= DIV_LAST;
                            state     <= S_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_WAIT_RD: begin
                    if (rd_ready) begin
                        if (remaining == 32'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            word_ready <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_shift_engine.sv
// Testbench for bitstream_shift_engine: random and directed transfers checked
// against a bit-level reference built from the words and bit_length.
// fpga_tail is looped back from fpga_head.

module tb_bitstream_shift_engine;

    localparam int CLK_DIV = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] bit_length;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] checksum;
    logic        busy;
    logic        done;
    logic        prog_clk;
    logic        fpga_head;
    logic        fpga_tail;
    logic        rd_hold;

    bitstream_shift_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bit_length (bit_length),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .checksum   (checksum),
        .busy       (busy),
        .done       (done),
        .prog_clk   (prog_clk),
        .fpga_head  (fpga_head),
        .fpga_tail  (fpga_tail)
    );

    assign fpga_tail = fpga_head;
    assign rd_ready  = ~rd_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Observation of the serial side and the readback port.
    logic        prev_pc = 1'b0;
    logic        prev_rdv = 1'b0;
    logic        prev_rdr = 1'b0;
    logic [31:0] prev_rdd = '0;
    int          rises = 0;
    int          done_cnt = 0;
    int          hold_err = 0;
    int          gap_err = 0;
    int          acc_cyc = 0;
    bit          got_bits[$];
    logic [31:0] got_rd[$];
    logic [31:0] wq[$];

    always @(negedge clk) begin
        #1;
        if (prog_clk && !prev_pc) begin
            rises++;
            got_bits.push_back(fpga_head);
        end
        prev_pc = prog_clk;
        if (done) done_cnt++;
        if (rd_valid && rd_ready) got_rd.push_back(rd_data);
        if (prev_rdv && !prev_rdr && (!rd_valid || rd_data !== prev_rdd)) hold_err++;
        prev_rdv = rd_valid;
        prev_rdr = rd_ready;
        prev_rdd = rd_data;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int b;
        repeat (gap) begin
            tick();
            if (word_ready && prog_clk) gap_err++;
        end
        word_data  = w;
        word_valid = 1'b1;
        b = 0;
        while (!word_ready && b < 1000) begin
            tick();
            b++;
        end
        if (b >= 1000) check_val("word_ready_timeout", 32'(word_ready), 32'd1);
        acc_cyc = cyc;
        tick();
        word_valid = 1'b0;
        word_data  = $urandom;
    endtask

    task automatic xfer(input int len, input logic [31:0] wi[$], input int gap,
                        input bit hold, input bit poke);
        logic [31:0] words[$];
        logic [31:0] exp_sum;
        logic [31:0] w;
        int nwords, klast, r0, d0, b, nerr, kb;
        nwords  = (len + 31) / 32;
        exp_sum = '0;
        #2;
        r0 = rises;
        d0 = done_cnt;
        got_bits.delete();
        got_rd.delete();
        tick();
        rd_hold    = hold;
        bit_length = 32'(len);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        bit_length = $urandom;
        check_val("ready_after_start", 32'(word_ready), 32'd1);
        check_val("busy_after_start", 32'(busy), 32'd1);
        for (int j = 0; j < nwords; j++) begin
            w = (j < wi.size()) ? wi[j] : $urandom;
            words.push_back(w);
            exp_sum = exp_sum + w;
            send_word(w, (j == 0) ? 0 : gap);
            if (poke && j == 0) begin
                start      = 1'b1;
                bit_length = 32'd7;
                tick();
                start = 1'b0;
            end
        end
        klast = len - 32 * (nwords - 1);
        if (hold) begin
            b = 0;
            while ((rises - r0) < 64 && b < 2000) begin
                tick();
                b++;
            end
            repeat (4 * CLK_DIV + 10) tick();
            #2;
            check_val("hold_rises", 32'(rises - r0), 32'd64);
            check_val("hold_prog_clk", 32'(prog_clk), 32'd0);
            check_val("hold_busy", 32'(busy), 32'd1);
            check_val("hold_rd_valid", 32'(rd_valid), 32'd1);
            check_val("hold_no_done", 32'(done_cnt - d0), 32'd0);
            tick();
            rd_hold = 1'b0;
        end
        b = 0;
        while (!done && b < 3000) begin
            tick();
            b++;
        end
        if (!done) check_val("done_timeout", 32'(done), 32'd1);
        if (!hold) check_val("done_latency", 32'(cyc - acc_cyc), 32'(2 * CLK_DIV * klast + 1));
        check_val("checksum", checksum, exp_sum);
        tick();
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("done_one_cycle", 32'(done), 32'd0);
        #2;
        check_val("prog_clk_rises", 32'(rises - r0), 32'(len));
        check_val("done_count", 32'(done_cnt - d0), 32'd1);
        nerr = 0;
        if (got_bits.size() != len) begin
            nerr = len;
        end else begin
            for (int i = 0; i < len; i++) begin
                w = words[i / 32];
                if (got_bits[i] != w[31 - (i % 32)]) nerr++;
            end
        end
        check_val("head_bit_errors", 32'(nerr), 32'd0);
`ifdef BITSTREAM_READBACK_EN
        check_val("rd_word_count", 32'(got_rd.size()), 32'(nwords));
        for (int j = 0; j < nwords && j < got_rd.size(); j++) begin
            kb = (j == nwords - 1) ? klast : 32;
            check_val("rd_data", got_rd[j], words[j] >> (32 - kb));
        end
`endif
        rd_hold = 1'b0;
    endtask

    initial begin
        int r0, d0, b, n;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        bit_length = '0;
        word_data  = '0;
        word_valid = 1'b0;
        rd_hold    = 1'b0;

        repeat (3) tick();
        check_val("rst_prog_clk", 32'(prog_clk), 32'd0);
        check_val("rst_fpga_head", 32'(fpga_head), 32'd0);
        check_val("rst_word_ready", 32'(word_ready), 32'd0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst_rd_data", rd_data, 32'd0);
        check_val("rst_checksum", checksum, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();

        // Single full word.
        wq.delete();
        wq.push_back(32'hA5000001);
        xfer(32, wq, 0, 1'b0, 1'b0);

        // Partial final word with back-pressure between words.
        wq.delete();
        wq.push_back(32'hFFFFFFFF);
        wq.push_back(32'h12345678);
        xfer(40, wq, 10, 1'b0, 1'b0);
        check_val("gap_prog_clk_low", 32'(gap_err), 32'd0);

`ifdef BITSTREAM_READBACK_EN
        // Readback consumer stalls across the second word end.
        wq.delete();
        wq.push_back(32'h12345678);
        xfer(64, wq, 0, 1'b1, 1'b0);
`endif

        // Random lengths, words and gaps; one transfer sees a start while busy.
        wq.delete();
        for (int i = 0; i < 6; i++)
            xfer($urandom_range(1, 100), wq, $urandom_range(0, 5), 1'b0, i == 2);
        check_val("gap_prog_clk_low_rand", 32'(gap_err), 32'd0);

        // Zero length: done without any prog_clk edge, checksum cleared.
        tick();
        #2;
        r0 = rises;
        d0 = done_cnt;
        tick();
        bit_length = 32'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 2) begin
            tick();
            n++;
        end
        check_val("zero_len_done", 32'(done), 32'd1);
        check_val("zero_len_checksum", checksum, 32'd0);
        repeat (5) tick();
        #2;
        check_val("zero_len_rises", 32'(rises - r0), 32'd0);
        check_val("zero_len_done_count", 32'(done_cnt - d0), 32'd1);

        // Abort in the middle of a word.
        tick();
        bit_length = 32'd64;
        start      = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hFFFFFFFF, 0);
        repeat (9) tick();
        check_val("pre_abort_head", 32'(fpga_head), 32'd1);
        #2;
        d0 = done_cnt;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_prog_clk", 32'(prog_clk), 32'd0);
        check_val("abort_fpga_head", 32'(fpga_head), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_word_ready", 32'(word_ready), 32'd0);
        check_val("abort_rd_valid", 32'(rd_valid), 32'd0);
        repeat (20) tick();
        #2;
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);

        wq.delete();
        xfer(33, wq, 2, 1'b0, 1'b0);

        // Asynchronous reset while prog_clk is high.
        tick();
        bit_length = 32'd32;
        start      = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hFFFFFFFF, 0);
        b = 0;
        while (!prog_clk && b < 100) begin
            tick();
            b++;
        end
        check_val("pre_reset_prog_clk", 32'(prog_clk), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("areset_prog_clk", 32'(prog_clk), 32'd0);
        check_val("areset_fpga_head", 32'(fpga_head), 32'd0);
        check_val("areset_busy", 32'(busy), 32'd0);
        check_val("areset_checksum", checksum, 32'd0);
        check_val("areset_word_ready", 32'(word_ready), 32'd0);
        check_val("areset_rd_valid", 32'(rd_valid), 32'd0);
        check_val("areset_done", 32'(done), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        wq.delete();
        xfer(32, wq, 0, 1'b0, 1'b0);
        check_val("rd_hold_stable", 32'(hold_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
